alu_dispatch: RTL
=================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, the operand width.
REQ-002 The block SHALL have parameter ID_SIZE, default 8, the transaction ID width.
REQ-003 The block SHALL have parameter OPERATION_SIZE, default 2, the opcode width.
REQ-004 The block SHALL derive FIFO_IN_WIDTH = 2*DATA_SIZE+ID_SIZE+OPERATION_SIZE (42) and FIFO_OUT_WIDTH = ID_SIZE+DATA_SIZE+1 (25); these are not overridable.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with the following ports.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-high reset.
- fifo_in_data  input  FIFO_IN_WIDTH  FIFO_IN read data: [1:0] op, [9:2] id, [25:10] operand A, [41:26] operand B.
- fifo_in_empty  input  1  FIFO_IN empty flag.
- fifo_in_r_en  output  1  FIFO_IN pop strobe; read data is valid the cycle after the strobe.
- fifo_out_full  input  1  FIFO_OUT full flag.
- fifo_out_w_en  output  1  FIFO_OUT push strobe.
- fifo_out_wdata  output  FIFO_OUT_WIDTH  result word: [24:17] id, [16:0] result.
- busy  output  1  high in every state except IDLE.
- done_count  output  16  number of results pushed.

Function
REQ-006 The block SHALL implement a Moore FSM with states IDLE, READ, CAPTURE, EXEC and WRITE; all outputs SHALL be registered or decoded from state only.
REQ-007 IDLE: if fifo_in_empty=0 at a rising edge, the FSM SHALL go to READ; otherwise it SHALL stay in IDLE.
REQ-008 READ: fifo_in_r_en SHALL be 1 for exactly this one cycle, then the FSM SHALL go to CAPTURE.
REQ-009 CAPTURE: the block SHALL latch op, id, A and B from fifo_in_data, then go to EXEC.
REQ-010 EXEC: the block SHALL compute the result into a result register, then go to WRITE.
REQ-011 op 00 (ADD) SHALL produce the 17-bit sum {0,A}+{0,B}, with bit16 as the carry.
REQ-012 op 01 (SUB) SHALL produce the 17-bit value {0,A}-{0,B} modulo 2^17, with bit16 as the borrow.
REQ-013 op 10 (AND) SHALL produce {0, A&B}.
REQ-014 op 11 (XOR) SHALL produce {0, A^B}.
REQ-015 WRITE: fifo_out_wdata SHALL equal {id, result} for the whole state.
REQ-016 WRITE: if fifo_out_full=0, fifo_out_w_en SHALL be 1 for exactly one cycle, done_count SHALL increment and the FSM SHALL return to IDLE.
REQ-017 WRITE: if fifo_out_full=1, fifo_out_w_en SHALL be 0 and the FSM SHALL hold in WRITE with fifo_out_wdata stable, for any number of cycles.
REQ-018 fifo_in_r_en SHALL never be asserted outside READ, and fifo_out_w_en SHALL never be asserted outside WRITE.
REQ-019 The block SHALL allow at most one transaction in flight; FIFO_IN SHALL not be popped again until the previous result has been pushed.
REQ-020 Latency: with FIFO_OUT not full, fifo_out_w_en SHALL assert exactly 3 cycles after fifo_in_r_en.
REQ-021 Throughput: the minimum spacing between consecutive fifo_in_r_en pulses SHALL be 5 cycles.
REQ-022 fifo_in_empty SHALL be sampled only in IDLE; a change of that flag in any other state SHALL have no effect.
REQ-023 done_count SHALL wrap from 0xFFFF to 0x0000 with no flag.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL set state to IDLE, fifo_in_r_en, fifo_out_w_en and busy to 0, fifo_out_wdata to 0, done_count to 0, and clear the captured operands.
REQ-025 Reset SHALL take priority over all other inputs.
REQ-026 Reset asserted in any state SHALL discard the in-flight transaction with no push.
REQ-027 The block SHALL have no asynchronous reset path.

Verification
REQ-028 ADD: FIFO_IN holds op=00, id=0x5A, A=0xFFFF, B=0x0001 -> one r_en, then 3 cycles later w_en with wdata = {0x5A, 0x10000}, and done_count=1.
REQ-029 SUB: op=01, id=0x03, A=0x0001, B=0x0002 -> wdata = {0x03, 0x1FFFF}; also check AND 0xF0F0&0xFF00 -> 0x0F000 and XOR 0xAAAA^0x5555 -> 0x0FFFF.
REQ-030 Backpressure: fifo_out_full=1 held for 10 cycles during WRITE -> w_en stays 0 and wdata is stable; full drops -> exactly one w_en with the correct word.
REQ-031 Reset mid-op: rst pulsed in EXEC -> no w_en, busy=0, done_count=0; the next FIFO_IN entry is processed normally.
REQ-032 Stream: 4 entries queued, FIFO_OUT never full -> r_en pulses exactly 5 cycles apart, results in order, done_count=4.
REQ-033 Wrap: done_count preset by 65535 completions (or forced) -> the next push gives done_count=0.

Source files
------------

// File: rtl/alu_dispatch.sv
// Single-transaction ALU dispatcher: pops one operand word from FIFO_IN,
// computes ADD/SUB/AND/XOR and pushes {id, result} into FIFO_OUT.
module alu_dispatch #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  localparam int FIFO_IN_WIDTH  = 2 * DATA_SIZE + ID_SIZE + OPERATION_SIZE,
  localparam int FIFO_OUT_WIDTH = ID_SIZE + DATA_SIZE + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_data,
  input  logic                      fifo_in_empty,
  output logic                      fifo_in_r_en,
  input  logic                      fifo_out_full,
  output logic                      fifo_out_w_en,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_out_wdata,
  output logic                      busy,
  output logic [15:0]               done_count
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRead    = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StExec    = 3'd3;
  localparam logic [2:0] StWrite   = 3'd4;

  localparam int IdLsb = OPERATION_SIZE;
  localparam int ALsb  = OPERATION_SIZE + ID_SIZE;
  localparam int BLsb  = OPERATION_SIZE + ID_SIZE + DATA_SIZE;

  logic [2:0]                state_q, state_d;
  logic [OPERATION_SIZE-1:0] op_q;
  logic [ID_SIZE-1:0]        id_q;
  logic [DATA_SIZE-1:0]      a_q, b_q;
  logic [DATA_SIZE:0]        result_q, result_d;
  logic [15:0]               done_count_q;
  logic                      push;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!fifo_in_empty) state_d = StRead;
      StRead:    state_d = StCapture;
      StCapture: state_d = StExec;
      StExec:    state_d = StWrite;
      StWrite:   if (!fifo_out_full) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Carry / borrow fall out of the extra MSB on the zero-extended operands.
  always_comb begin
    result_d = '0;
    case (op_q)
      OPERATION_SIZE'(0): result_d = {1'b0, a_q} + {1'b0, b_q};
      OPERATION_SIZE'(1): result_d = {1'b0, a_q} - {1'b0, b_q};
      OPERATION_SIZE'(2): result_d = {1'b0, a_q & b_q};
      OPERATION_SIZE'(3): result_d = {1'b0, a_q ^ b_q};
      default:            result_d = '0;
    endcase
  end

  assign push = (state_q == StWrite) && !fifo_out_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      done_count_q <= '0;
    end else begin
      state_q <= state_d;
      // Read data is valid the cycle after the pop strobe, i.e. during CAPTURE.
      if (state_q == StCapture) begin
        op_q <= fifo_in_data[OPERATION_SIZE-1:0];
        id_q <= fifo_in_data[IdLsb +: ID_SIZE];
        a_q  <= fifo_in_data[ALsb +: DATA_SIZE];
        b_q  <= fifo_in_data[BLsb +: DATA_SIZE];
      end
      if (state_q == StExec) result_q <= result_d;
      if (push) done_count_q <= done_count_q + 16'd1;
    end
  end

  assign fifo_in_r_en   = (state_q == StRead);
  assign fifo_out_w_en  = push;
  assign fifo_out_wdata = {id_q, result_q};
  assign busy           = (state_q != StIdle);
  assign done_count     = done_count_q;

endmodule
